// File: rtl/quant_rr_scheduler.sv
// Round-robin arbiter sharing one fixed-point quantize stage between NREQ producers.
// Optional build macro QUANT_ROUND_EN selects round-half-up with saturation instead of truncation.
module quant_rr_scheduler #(
  parameter int N    = 16,
  parameter int Q    = 12,
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready,
  output logic [31:0]       xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             load_en;
  logic             load;
  logic [N-1:0]     winner_data;
  logic [N-1:0]     quant_data;

`ifdef QUANT_ROUND_EN
  logic [N:0]       rounded;
`endif

  // Search order starts just past the last winner, so a stall never rotates priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(last_grant) + 1 + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign load_en     = (state == EMPTY) | out_ready;
  assign load        = load_en & (|req_valid);
  assign winner_data = req_data[winner*N +: N];

  always_comb begin
    req_ready = '0;
    if (load && found) begin
      req_ready[winner] = 1'b1;
    end
  end

`ifdef QUANT_ROUND_EN
  // Positive inputs near full scale would wrap into the sign bit, so clamp them.
  always_comb begin
    rounded = {winner_data[N-1], winner_data} + (N+1)'(1 << (Q-2));
    if (!winner_data[N-1] && rounded[N-1]) begin
      quant_data = {1'b0, {(N-Q){1'b1}}, {(Q-1){1'b0}}};
    end else begin
      quant_data = {rounded[N-1:Q-1], {(Q-1){1'b0}}};
    end
  end
`else
  always_comb begin
    quant_data = {winner_data[N-1:Q-1], {(Q-1){1'b0}}};
  end
`endif

  // The FSM tracks occupancy of the output register; drain and refill may share one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      xfer_cnt   <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (load) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (out_ready && !load) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
      if (load) begin
        out_data   <= quant_data;
        out_id     <= winner;
        last_grant <= winner;
        xfer_cnt   <= xfer_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_quant_rr_scheduler.sv
// Directed self-checking bench for quant_rr_scheduler at N=16, Q=12, NREQ=4.
// Expected quantized words follow the build: QUANT_ROUND_EN selects the rounding table.
`timescale 1ns/1ps
module tb_quant_rr_scheduler;

  localparam int N    = 16;
  localparam int Q    = 12;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [N-1:0]      out_data;
  logic [IDW-1:0]    out_id;
  logic              out_ready;
  logic [31:0]       xfer_cnt;

  int checks;
  int errors;

  // Hand-computed quantized values for the data words used below.
`ifdef QUANT_ROUND_EN
  localparam logic [15:0] Q_1ABC = 16'h1800;
  localparam logic [15:0] Q_FC00 = 16'h0000;
  localparam logic [15:0] Q_1CBC = 16'h2000;
  localparam logic [15:0] Q_7FFF = 16'h7800;
  localparam logic [15:0] Q_7E00 = 16'h7800;
`else
  localparam logic [15:0] Q_1ABC = 16'h1800;
  localparam logic [15:0] Q_FC00 = 16'hF800;
  localparam logic [15:0] Q_1CBC = 16'h1800;
  localparam logic [15:0] Q_7FFF = 16'h7800;
  localparam logic [15:0] Q_7E00 = 16'h7800;
`endif

  quant_rr_scheduler #(.N(N), .Q(Q), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1ns past it, away from the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkLoad(input string tag, input logic [1:0] id, input logic [15:0] data, input int cnt);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_id"}, 32'(out_id), 32'(id));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(data));
    checkOutput({tag, "_cnt"}, xfer_cnt, 32'(cnt));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    req_data  = {16'h7FFF, 16'h1CBC, 16'hFC00, 16'h1ABC};

    // Reset and idle
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();
    checkOutput("idle_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_data", 32'(out_data), 32'd0);
    checkOutput("idle_ready", 32'(req_ready), 32'd0);
    checkOutput("idle_cnt", xfer_cnt, 32'd0);

    // All requesters valid, full throughput: ids 0,1,2,3,0,1
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    checkOutput("first_ready", 32'(req_ready), 32'b0001);
    applyStimulus(); checkLoad("rr0", 2'd0, Q_1ABC, 1);
    applyStimulus(); checkLoad("rr1", 2'd1, Q_FC00, 2);
    applyStimulus(); checkLoad("rr2", 2'd2, Q_1CBC, 3);
    applyStimulus(); checkLoad("rr3", 2'd3, Q_7FFF, 4);
    applyStimulus(); checkLoad("rr4", 2'd0, Q_1ABC, 5);
    applyStimulus(); checkLoad("rr5", 2'd1, Q_FC00, 6);

    // Load req2, then stall three cycles
    applyStimulus(); checkLoad("ld2", 2'd2, Q_1CBC, 7);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
      applyStimulus();
      checkLoad("stall", 2'd2, Q_1CBC, 7);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_ready", 32'(req_ready), 32'b1000);
    applyStimulus(); checkLoad("after_stall", 2'd3, Q_7FFF, 8);

    // Only req1, with single-cycle gaps
    req_valid = 4'b0010;
    #1;
    checkOutput("solo_ready", 32'(req_ready), 32'b0010);
    applyStimulus(); checkLoad("solo_a", 2'd1, Q_FC00, 9);
    req_valid = 4'b0000;
    req_data[31:16] = 16'h7E00;
    #1;
    checkOutput("gap_ready", 32'(req_ready), 32'd0);
    applyStimulus();
    checkOutput("gap_valid", 32'(out_valid), 32'd0);
    checkOutput("gap_cnt", xfer_cnt, 32'd9);
    req_valid = 4'b0010;
    applyStimulus(); checkLoad("solo_b", 2'd1, Q_7E00, 10);
    req_valid = 4'b0000;
    applyStimulus();
    checkOutput("gap2_valid", 32'(out_valid), 32'd0);
    checkOutput("gap2_cnt", xfer_cnt, 32'd10);

    // Reset mid-stream, asynchronous: check before any clock edge
    req_valid = 4'b0100;
    applyStimulus(); checkLoad("pre_rst", 2'd2, Q_1CBC, 11);
    req_valid = 4'b0000;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_data", 32'(out_data), 32'd0);
    checkOutput("arst_id", 32'(out_id), 32'd0);
    checkOutput("arst_cnt", xfer_cnt, 32'd0);
    checkOutput("arst_ready", 32'(req_ready), 32'd0);
    applyStimulus();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    checkOutput("post_rst_ready", 32'(req_ready), 32'b0001);
    applyStimulus(); checkLoad("post_rst", 2'd0, Q_1ABC, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
